vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 800x600 VGA controller.
- Generates hsync/vsync/data-enable and pixel coordinates for any timing set given by parameters, plus a built-in test-pattern source with runtime mode select.
- Sits between the pixel clock domain root and the VGA DAC/pin outputs.
- Also drives x/y/de to downstream pixel sources that overlay or replace the pattern.

Parameters:
- H_SYNC, 128, hsync pulse width in pixels
- H_BACK, 88, horizontal back porch in pixels
- H_ACTIVE, 800, visible pixels per line; must be a multiple of 8
- H_FRONT, 40, horizontal front porch in pixels
- V_SYNC, 4, vsync pulse width in lines
- V_BACK, 23, vertical back porch in lines
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch in lines
- H_POL, 1'b0, hsync asserted level (0 = active-low)
- V_POL, 1'b0, vsync asserted level
- RGB_W, 8, colour width; RGB332 packing when 8
- CNT_W, 12, width of the x/y counters and outputs
- CHK_SHIFT, 5, checkerboard square size = 2^CHK_SHIFT pixels

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- mode  in  2  pattern select; sampled at frame start only
- solid_rgb  in  RGB_W  colour used in mode 0
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_de  out  1  active-video enable
- vga_x  out  CNT_W  active pixel column, 0..H_ACTIVE-1; holds 0 when de=0
- vga_y  out  CNT_W  active line, 0..V_ACTIVE-1; holds 0 when de=0
- vga_rgb  out  RGB_W  pixel colour; 0 outside active area
- frame_start  out  1  one-cycle pulse coincident with first vsync-asserted cycle
- line_start  out  1  one-cycle pulse coincident with first hsync-asserted cycle of every line

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Line order: sync, back porch, active, front porch. H_TOTAL = sum of the four H parameters (1056 by default); V_TOTAL = sum of the four V parameters (628 by default).
- Counters:
  - hcnt runs 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments when hcnt == H_TOTAL-1, and wraps to 0 when also vcnt == V_TOTAL-1.
- Decode, on counter values:
  - hs active when hcnt < H_SYNC.
  - vs active when vcnt < V_SYNC; vsync changes on hcnt == 0 boundaries only.
  - de when hcnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and vcnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE).
- Pipeline: every output is registered, with exactly 1 cycle of latency from counter state. hs, vs, de, x, y, rgb, frame_start and line_start stay mutually aligned.
- Reset: in the cycle after rst is sampled high:
  - hcnt = vcnt = 0;
  - vga_hs = ~H_POL, vga_vs = ~V_POL;
  - de, x, y, rgb, frame_start and line_start = 0;
  - latched mode = 0.
- After reset release: first output cycle has hs and vs asserted, and frame_start = line_start = 1.
- Reset mid-frame restarts timing at hcnt = vcnt = 0 with no partial pulse stretching.
- Mode latch: mode is captured at hcnt == 0 && vcnt == 0 only. A change mid-frame has no visible effect until the next frame.
- Patterns (active area only):
  - mode 0: solid_rgb, sampled every pixel.
  - mode 1: 8 vertical bars of width H_ACTIVE/8, colours from the package table (white, yellow, cyan, green, magenta, red, blue, black). Bar index comes from a bar counter that is reset at active start and steps every H_ACTIVE/8 pixels. No divider.
  - mode 2: checkerboard; white when x[CHK_SHIFT] ^ y[CHK_SHIFT] == 1, else black.
  - mode 3: black.
- Outside active area rgb = 0 regardless of mode.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: pixels with x == 0, x == H_ACTIVE-1, y == 0 or y == V_ACTIVE-1 output all-ones (white), overriding every mode including mode 3. Latency is unchanged.
- When undefined: no border logic; patterns are as above.

Decomposition:
- Package vga_pkg:
  - pattern mode enum (PAT_SOLID, PAT_BARS, PAT_CHECKER, PAT_BLACK);
  - 8-entry bar colour constant table in RGB332;
  - default 800x600@60 timing constants.
- Sub-module vga_axis_counter, instantiated once per axis:
  - inputs: count enable and wrap;
  - parameters: SYNC/BACK/ACTIVE/FRONT;
  - outputs: count, sync_active, active, active_pos.

Test Plan:
- Default parameters, reset released: hsync low for 128 cycles every 1056 cycles; vsync low for exactly 4x1056 cycles every 663168 cycles; frame_start period 663168.
- de timing: first de at 1 cycle after hcnt = 216, vcnt = 27; 800 consecutive de cycles per line; 600 de lines per frame; x runs 0..799 and y runs 0..599.
- mode = 1: x = 0..99 gives rgb 8'hFF, x = 100..199 gives 8'hFC, x = 700..799 gives 8'h00; rgb = 0 while de = 0.
- mode changed 0 → 2 at vcnt = 300: rest of the frame stays solid; next frame shows checker, with (x,y) = (32,0) white and (32,32) black.
- rst pulsed for 1 cycle at hcnt = 500, vcnt = 400: next cycle counters are 0 and hs/vs are deasserted; the cycle after that has frame_start = 1; no vsync pulse shorter than 4 lines is observed.
- H_POL = V_POL = 1 with 640x480 parameters (96/48/640/16, 2/33/480/10): sync active-high, total 800x525, de count 307200 per frame; with VGA_BORDER_EN, pixel (639,479) = 8'hFF in mode 3.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the parametrised VGA timing generator:
// pattern modes, the RGB332 colour-bar table and default 800x600@60 timing.
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BLACK   = 2'd3
  } pat_mode_e;

  // Element 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][7:0] BAR_RGB332 = {
    8'h00, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF
  };

  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: free-running position counter plus sync/active decode.
// Instantiated once for the horizontal and once for the vertical axis.
module vga_axis_counter #(
  parameter int SYNC   = 128,
  parameter int BACK   = 88,
  parameter int ACTIVE = 800,
  parameter int FRONT  = 40,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  output logic [CNT_W-1:0] count,
  output logic             at_last,
  output logic             sync_active,
  output logic             active,
  output logic [CNT_W-1:0] active_pos
);

  localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BACK);
  localparam logic [CNT_W-1:0] ACT_END   = CNT_W'(SYNC + BACK + ACTIVE);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(SYNC + BACK + ACTIVE + FRONT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count       = count_q;
  assign at_last     = (count_q == LAST);
  assign sync_active = (count_q < SYNC_END);
  assign active      = (count_q >= ACT_START) && (count_q < ACT_END);
  assign active_pos  = active ? count_q - ACT_START : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/DE/coordinate generator with built-in test patterns.
// Optional VGA_BORDER_EN draws a white one-pixel frame around the active area.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BACK    = DEF_H_BACK,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FRONT   = DEF_H_FRONT,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BACK    = DEF_V_BACK,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FRONT   = DEF_V_FRONT,
  parameter logic H_POL     = 1'b0,
  parameter logic V_POL     = 1'b0,
  parameter int   RGB_W     = 8,
  parameter int   CNT_W     = 12,
  parameter int   CHK_SHIFT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] solid_rgb,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [CNT_W-1:0] vga_x,
  output logic [CNT_W-1:0] vga_y,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             line_start
);

  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);
`ifdef VGA_BORDER_EN
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
`endif

  logic [CNT_W-1:0] h_cnt, h_pos, v_cnt, v_pos;
  logic             h_last, h_sync, h_act, v_last, v_sync, v_act;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .en(1'b1), .wrap(h_last),
    .count(h_cnt), .at_last(h_last), .sync_active(h_sync),
    .active(h_act), .active_pos(h_pos)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .en(h_last), .wrap(v_last),
    .count(v_cnt), .at_last(v_last), .sync_active(v_sync),
    .active(v_act), .active_pos(v_pos)
  );

  pat_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [RGB_W-1:0] rgb_q, rgb_d, pat_rgb;
  logic             frame_top;

  assign frame_top = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    mode_d = mode_q;
    if (frame_top) mode_d = pat_mode_e'(mode);

    // Bar counter idles at zero outside active so each line starts on bar 0
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (h_act) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CNT_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end

    case (mode_q)
      PAT_SOLID:   pat_rgb = solid_rgb;
      PAT_BARS:    pat_rgb = RGB_W'(BAR_RGB332[bar_idx_q]);
      PAT_CHECKER: pat_rgb = (h_pos[CHK_SHIFT] ^ v_pos[CHK_SHIFT]) ? '1 : '0;
      default:     pat_rgb = '0;
    endcase
`ifdef VGA_BORDER_EN
    if (h_pos == '0 || h_pos == X_LAST || v_pos == '0 || v_pos == Y_LAST) pat_rgb = '1;
`endif

    de_d  = h_act && v_act;
    hs_d  = h_sync ? H_POL : ~H_POL;
    vs_d  = v_sync ? V_POL : ~V_POL;
    x_d   = de_d ? h_pos : '0;
    y_d   = de_d ? v_pos : '0;
    rgb_d = de_d ? pat_rgb : '0;
    fs_d  = frame_top;
    ls_d  = (h_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= PAT_SOLID;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      hs_q      <= ~H_POL;
      vs_q      <= ~V_POL;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
      ls_q      <= ls_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken timing set: arithmetic reference model
// checked every cycle, plus literal timing/pattern probes and random stimulus.
module tb_vga_timing_gen;

  localparam int HS = 8, HB = 6, HA = 32, HF = 4;
  localparam int VS = 2, VB = 3, VA = 20, VF = 2;
  localparam int HT = HS + HB + HA + HF;   // 50
  localparam int VT = VS + VB + VA + VF;   // 27
  localparam int FRAME = HT * VT;          // 1350
  localparam logic HP = 1'b0, VP = 1'b1;
  localparam int CS = 2;
  localparam int CW = 8;

  logic          clk, rst;
  logic [1:0]    mode;
  logic [7:0]    solid_rgb;
  logic          vga_hs, vga_vs, vga_de, frame_start, line_start;
  logic [CW-1:0] vga_x, vga_y;
  logic [7:0]    vga_rgb;

  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .H_POL(HP), .V_POL(VP), .RGB_W(8), .CNT_W(CW), .CHK_SHIFT(CS)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .solid_rgb(solid_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_x(vga_x), .vga_y(vga_y), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .line_start(line_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(int m, int x, int y, logic [7:0] s);
    logic [7:0] tbl [8];
    tbl = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
`ifdef VGA_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 8'hFF;
`endif
    case (m)
      0:       return s;
      1:       return tbl[x / (HA / 8)];
      2:       return ((((x >> CS) ^ (y >> CS)) & 1) != 0) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: position in the frame and latched mode, advanced per clock
  int hc = 0, vc = 0, ml = 0;
  bit ev = 0;
  logic e_hs, e_vs, e_de, e_fs, e_ls;
  int   e_x, e_y;
  logic [7:0] e_rgb;

  always @(posedge clk) begin
    int xi, yi;
    if (rst) begin
      e_hs = ~HP; e_vs = ~VP; e_de = 0; e_x = 0; e_y = 0; e_rgb = 0;
      e_fs = 0; e_ls = 0; hc = 0; vc = 0; ml = 0; ev = 1;
    end else begin
      xi    = hc - (HS + HB);
      yi    = vc - (VS + VB);
      e_hs  = (hc < HS) ? HP : ~HP;
      e_vs  = (vc < VS) ? VP : ~VP;
      e_de  = (xi >= 0) && (xi < HA) && (yi >= 0) && (yi < VA);
      e_x   = e_de ? xi : 0;
      e_y   = e_de ? yi : 0;
      e_rgb = e_de ? pattern(ml, xi, yi, solid_rgb) : 8'h00;
      e_fs  = (hc == 0) && (vc == 0);
      e_ls  = (hc == 0);
      if (hc == 0 && vc == 0) ml = int'(mode);
      hc++;
      if (hc == HT) begin
        hc = 0;
        vc++;
        if (vc == VT) vc = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (ev) begin
      n_cmp++;
      if (vga_hs !== e_hs || vga_vs !== e_vs || vga_de !== e_de ||
          int'(vga_x) != e_x || int'(vga_y) != e_y || vga_rgb !== e_rgb ||
          frame_start !== e_fs || line_start !== e_ls) begin
        n_bad++;
        $display("FAIL outputs @%0t: got hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h fs=%b ls=%b want hs=%b vs=%b de=%b x=%0d y=%0d rgb=%h fs=%b ls=%b",
                 $time, vga_hs, vga_vs, vga_de, vga_x, vga_y, vga_rgb, frame_start, line_start,
                 e_hs, e_vs, e_de, e_x, e_y, e_rgb, e_fs, e_ls);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_fs();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (frame_start) found = 1;
    end
    if (!found) chk("wait_frame_start_timeout", 0, 1);
  endtask

  task automatic wait_pixel(input int x, input int y, output logic [7:0] rgb);
    bit found = 0;
    rgb = 8'h00;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (vga_de && int'(vga_x) == x && int'(vga_y) == y) begin
        found = 1;
        rgb = vga_rgb;
      end
    end
    if (!found) chk("wait_pixel_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] px;
    int n_hs, n_vs, n_de, n_fs, n_ls;
    rst = 1'b1; mode = 2'd0; solid_rgb = 8'h5A;
    step(); step();
    chk("reset_hs", int'(vga_hs), 1);
    chk("reset_vs", int'(vga_vs), 0);
    chk("reset_de", int'(vga_de), 0);
    chk("reset_fs", int'(frame_start), 0);
    rst = 1'b0;
    step();
    chk("first_hs", int'(vga_hs), 0);
    chk("first_vs", int'(vga_vs), 1);
    chk("first_fs", int'(frame_start), 1);
    chk("first_ls", int'(line_start), 1);

    n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_ls = 0;
    for (int i = 0; i < FRAME; i++) begin
      n_hs += (vga_hs == 1'b0) ? 1 : 0;
      n_vs += (vga_vs == 1'b1) ? 1 : 0;
      n_de += vga_de ? 1 : 0;
      n_fs += frame_start ? 1 : 0;
      n_ls += line_start ? 1 : 0;
      step();
    end
    chk("frame_period_fs", int'(frame_start), 1);
    chk("hs_cycles", n_hs, 216);
    chk("vs_cycles", n_vs, 100);
    chk("de_cycles", n_de, 640);
    chk("fs_count", n_fs, 1);
    chk("ls_count", n_ls, 27);

    mode = 2'd1;
    wait_fs();
    wait_pixel(0, 1, px);  chk("bars_x0", int'(px), 8'hFF);
    wait_pixel(4, 1, px);  chk("bars_x4", int'(px), 8'hFC);
    wait_pixel(28, 1, px); chk("bars_x28", int'(px), 8'h00);

    mode = 2'd0;
    wait_fs();
    wait_pixel(0, 10, px);
    mode = 2'd2;
    wait_pixel(16, 12, px); chk("mode_held_mid_frame", int'(px), 8'h5A);
    wait_fs();
    wait_pixel(4, 1, px);  chk("checker_white", int'(px), 8'hFF);
    wait_pixel(4, 4, px);  chk("checker_black", int'(px), 8'h00);

    wait_pixel(10, 8, px);
    rst = 1'b1;
    step();
    chk("midrst_hs_idle", int'(vga_hs), 1);
    chk("midrst_vs_idle", int'(vga_vs), 0);
    chk("midrst_de", int'(vga_de), 0);
    rst = 1'b0;
    step();
    chk("midrst_fs", int'(frame_start), 1);
    chk("midrst_vs_on", int'(vga_vs), 1);

    for (int c = 0; c < 20000; c++) begin
      step();
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      solid_rgb = 8'($urandom);
      rst = ($urandom_range(0, 2999) == 0);
    end
    rst = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
